// File: rtl/simple_cpu_mem_pkg.sv
// simple_cpu_mem_pkg
// Shared types and constants for the simple_cpu_mem memory responder.
//   ld_state_t : program-loader FSM states (RUN, LD_HI, LD_LO)
//   IM_W       : instruction word width
//   DM_W       : data byte width
//   A_W        : CPU address bus width
//   addr_bits  : index width for a RAM of the given power-of-two depth
package simple_cpu_mem_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LD_HI = 2'd1,
        LD_LO = 2'd2
    } ld_state_t;

    localparam int IM_W = 16;
    localparam int DM_W = 8;
    localparam int A_W  = 8;

    // A depth of 1 still needs a one-bit index to keep the RAM declarations legal.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/simple_cpu_mem_loader.sv
// simple_cpu_mem_loader
// Byte-serial program loader. Collects high/low byte pairs into 16-bit
// instruction words and presents them on an instruction-RAM write port.
// Holds the CPU in reset while a load is in progress.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   ld_start       : begin a load at word 0 (only honoured in RUN)
//   ld_valid       : loader byte present
//   ld_byte        : loader byte, high byte of each word first
//   ld_last        : marks the low byte of the final word
//   ld_ready       : byte accepted this cycle when ld_valid is high
//   ld_done        : one-cycle pulse after the final word is written
//   cpu_reset      : registered reset to the CPU
//   we, addr, data : instruction-RAM write port
module simple_cpu_mem_loader
    import simple_cpu_mem_pkg::*;
#(
    parameter int IM_DEPTH = 256,
    parameter int IM_AW    = addr_bits(IM_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [DM_W-1:0]  ld_byte,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             ld_done,
    output logic             cpu_reset,
    output logic             we,
    output logic [IM_AW-1:0] addr,
    output logic [IM_W-1:0]  data
);

    ld_state_t        state;
    ld_state_t        next_state;
    logic [IM_AW-1:0] ptr;
    logic [DM_W-1:0]  hi;

    // Next-state decode and the RAM write port. A word is written on the
    // low-byte transfer; the write is suppressed during reset so a reset that
    // lands on a low byte cannot leave a half-formed word behind.
    always_comb begin
        next_state = state;
        ld_ready   = (state != RUN);
        we         = (state == LD_LO) && ld_valid && !reset;
        addr       = ptr;
        data       = {hi, ld_byte};
        case (state)
            RUN:     if (ld_start) next_state = LD_HI;
            LD_HI:   if (ld_valid) next_state = LD_LO;
            LD_LO:   if (ld_valid) next_state = ld_last ? RUN : LD_HI;
            default: next_state = RUN;
        endcase
    end

    // cpu_reset covers both the current and the next state so it rises in the
    // cycle right after ld_start and stays up for one cycle after ld_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            ptr       <= '0;
            hi        <= '0;
            ld_done   <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            state     <= next_state;
            ld_done   <= (state == LD_LO) && ld_valid && ld_last;
            cpu_reset <= (state != RUN) || (next_state != RUN);
            if (state == RUN && ld_start) begin
                ptr <= '0;
            end
            if (state == LD_HI && ld_valid) begin
                hi <= ld_byte;
            end
            if (we) begin
                ptr <= (ptr == IM_AW'(IM_DEPTH - 1)) ? '0 : ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/simple_cpu_mem.sv
// simple_cpu_mem
// Memory responder for simple_cpu_top: instruction RAM on the fetch bus,
// data RAM on the read/write bus, and a byte-serial program loader.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   cpu_reset                      : reset to the CPU (reset and loading)
//   im_abus_valid, im_abus_data    : fetch request and address
//   im_dbus                        : fetched instruction, 1-cycle latency
//   rd_mem, wr_mem, dm_abus        : data read/write strobes and address
//   dm_out_dbus                    : write data from the CPU
//   dm_in_dbus                     : read data to the CPU, 1-cycle latency
//   ld_start, ld_valid, ld_byte,
//   ld_last, ld_ready, ld_done     : program loader handshake
module simple_cpu_mem
    import simple_cpu_mem_pkg::*;
#(
    parameter int IM_DEPTH = 256,
    parameter int DM_DEPTH = 256
) (
    input  logic            clk,
    input  logic            reset,
    output logic            cpu_reset,
    input  logic            im_abus_valid,
    input  logic [A_W-1:0]  im_abus_data,
    output logic [IM_W-1:0] im_dbus,
    input  logic            rd_mem,
    input  logic            wr_mem,
    input  logic [A_W-1:0]  dm_abus,
    input  logic [DM_W-1:0] dm_out_dbus,
    output logic [DM_W-1:0] dm_in_dbus,
    input  logic            ld_start,
    input  logic            ld_valid,
    input  logic [DM_W-1:0] ld_byte,
    input  logic            ld_last,
    output logic            ld_ready,
    output logic            ld_done
);

    localparam int IM_AW = addr_bits(IM_DEPTH);
    localparam int DM_AW = addr_bits(DM_DEPTH);

    logic [IM_W-1:0]  im [IM_DEPTH];
    logic [DM_W-1:0]  dm [DM_DEPTH];

    logic             ld_we;
    logic [IM_AW-1:0] ld_addr;
    logic [IM_W-1:0]  ld_data;

    // Upper address bits are dropped so out-of-range addresses alias.
    logic [IM_AW-1:0] im_idx;
    logic [DM_AW-1:0] dm_idx;

    assign im_idx = IM_AW'(im_abus_data);
    assign dm_idx = DM_AW'(dm_abus);

    simple_cpu_mem_loader #(
        .IM_DEPTH (IM_DEPTH)
    ) u_loader (
        .clk       (clk),
        .reset     (reset),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_byte   (ld_byte),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .cpu_reset (cpu_reset),
        .we        (ld_we),
        .addr      (ld_addr),
        .data      (ld_data)
    );

    always_ff @(posedge clk) begin
        if (ld_we) begin
            im[ld_addr] <= ld_data;
        end
    end

    // ld_ready doubles as the "loading" flag: fetches are ignored while it is up.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_dbus <= '0;
        end else if (im_abus_valid && !ld_ready) begin
            im_dbus <= im[im_idx];
        end
    end

    // Read and write share an edge; the non-blocking update gives
    // read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_mem) begin
            dm[dm_idx] <= dm_out_dbus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dm_in_dbus <= '0;
        end else if (rd_mem) begin
            dm_in_dbus <= dm[dm_idx];
        end
    end

endmodule

// File: doc/simple_cpu_mem.md
# simple_cpu_mem

Memory responder for `simple_cpu_top`. It serves the CPU's instruction-fetch bus from an internal 16-bit instruction RAM and its read/write data bus from an internal 8-bit data RAM. A byte-serial program loader fills instruction RAM. While loading, the block holds the CPU in reset through `cpu_reset`.

## Interface
Parameters:
- `IM_DEPTH`, default 256: instruction words. Power of two, ≤256.
- `DM_DEPTH`, default 256: data bytes. Power of two, ≤256.

Ports:
- `clk`  in  1  Single clock. All logic is on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `cpu_reset`  out  1  Reset to `simple_cpu_top`. High during reset and during loading.
- `im_abus_valid`  in  1  Fetch request from the CPU.
- `im_abus_data`  in  8  Fetch address.
- `im_dbus`  out  16  Fetched instruction: {opcode, operand}.
- `rd_mem`  in  1  Data read strobe.
- `wr_mem`  in  1  Data write strobe.
- `dm_abus`  in  8  Data address.
- `dm_out_dbus`  in  8  Write data from the CPU.
- `dm_in_dbus`  out  8  Read data to the CPU.
- `ld_start`  in  1  Begin a program load at word 0.
- `ld_valid`  in  1  A loader byte is present.
- `ld_byte`  in  8  Loader byte. Sent high byte first, then low byte.
- `ld_last`  in  1  Qualifies the low byte of the final word.
- `ld_ready`  out  1  The block accepts a byte this cycle.
- `ld_done`  out  1  One-cycle pulse when a load completes.

## Operation
- Address indexing: the low log2(DEPTH) address bits are used; upper bits are ignored, so out-of-range addresses alias into the RAM. RAM contents are not reset.
- Instruction fetch:
  - When `im_abus_valid=1` in RUN, `im_dbus` ← `im[addr]` on the next edge.
  - Otherwise `im_dbus` holds its value.
- Data read: when `rd_mem=1`, `dm_in_dbus` ← `dm[dm_abus]` on the next edge. Otherwise it holds.
- Data write: when `wr_mem=1`, `dm[dm_abus]` ← `dm_out_dbus` on the edge.
- Simultaneous `rd_mem` and `wr_mem` to the same address: the write happens and the read returns the OLD byte (read-before-write).
- Loader FSM states are RUN, LD_HI and LD_LO. A byte transfer occurs when `ld_valid & ld_ready`.
  - RUN: if `ld_start=1`, go to LD_HI and set `ptr`=0. `ld_start` is ignored in any other state.
  - LD_HI: on transfer, latch `hi`=`ld_byte` and go to LD_LO.
  - LD_LO: on transfer, write `im[ptr]`={hi, ld_byte} and increment `ptr`, wrapping modulo `IM_DEPTH`.
    - If `ld_last=1`: go to RUN and pulse `ld_done`.
    - Otherwise: go to LD_HI.
  - `ld_last` is ignored in LD_HI.
- `ld_ready`=1 exactly in LD_HI and LD_LO.
- `cpu_reset` is registered: 1 in the cycle after any reset cycle, and 1 in every cycle the FSM is in LD_HI or LD_LO.
- During a load, CPU fetch strobes are ignored. Data-bus strobes are still served, since the CPU is held in reset and does not drive them.
- Reset mid-load: the FSM returns to RUN. Words already written remain in the RAM; the partial `hi` byte is discarded.

## Timing
- Reset values: `im_dbus`=16'h0000, `dm_in_dbus`=8'h00, `ld_ready`=0, `ld_done`=0, `cpu_reset`=1, state=RUN, `ptr`=0.
- Fetch latency is 1 cycle: address at edge N, data valid after edge N+1.
- Data-read latency is 1 cycle. A write is visible to a read issued on the following cycle.
- Load sequence:
  - `ld_start` at edge N → `ld_ready`=1 and `cpu_reset`=1 from N+1.
  - Each word takes at least 2 cycles; idle cycles between bytes are allowed.
  - Final low byte at edge M → `ld_done`=1 and `ld_ready`=0 in cycle M+1.
  - `cpu_reset` falls at edge M+1 and is 0 from M+2.
- Back-to-back loads are allowed: `ld_start` may be asserted in the cycle `ld_done` is high.

## Structure
- Package `simple_cpu_mem_pkg` holds the loader state type (RUN, LD_HI, LD_LO), the width constants `IM_W`=16 and `DM_W`=8, and the address width `A_W`=8.
- Sub-module `simple_cpu_mem_loader` contains the FSM, `ptr`, `hi`, `ld_ready`, `ld_done` and `cpu_reset`. It outputs an instruction-RAM write port (`we`, `addr`, `data`).
- The two RAMs are inferred in the top.

## Test plan
- Reset check: assert reset for 2 cycles → `cpu_reset`=1, `im_dbus`=0, `dm_in_dbus`=0 and `ld_ready`=0 during reset; `cpu_reset`=0 two cycles after release.
- Program load:
  - Stimulus: `ld_start`, then bytes 12,34,56,78 with `ld_last` on 78.
  - Response: `im[0]`=16'h1234, `im[1]`=16'h5678, `ld_done` pulse for 1 cycle, `cpu_reset` low one cycle later.
  - Follow-up: fetch address 1 → `im_dbus`=16'h5678 after 1 cycle.
- Data bus:
  - Write 8'hA5 to address 8'h10, then read 8'h10 next cycle → `dm_in_dbus`=8'hA5.
  - Simultaneous rd/wr of 8'h3C to address 8'h10 → read returns 8'hA5, a later read returns 8'h3C.
- Gapped loader stimulus: toggle `ld_valid` with idle cycles between bytes and raise `ld_last` on a high byte → word written only on transfers, `ld_last` on the high byte ignored, the load ends only on a qualified low byte.
- Mid-load reset: assert reset after 3 bytes → `im[0]` retained, state RUN, `ld_ready`=0, `cpu_reset`=1 then 0; a new load starts again at `ptr`=0.
- Wrap and aliasing: with `IM_DEPTH`=4, load 5 words → word 4 overwrites `im[0]`. Fetch address 8'h05 → returns `im[1]`.
